// File: rtl/bootrom_arbiter.sv
// bootrom_arbiter: shares the single read port of the 2048x32 boot ROM between
// instruction fetch (r0) and the debug/system bus (r1), one transaction at a time.
module bootrom_arbiter #(
    parameter logic [31:0] BASE_ADDR  = 32'h0001_0000,
    parameter int          DEPTH_LOG2 = 11
) (
    input  logic                  clock,
    input  logic                  reset,

    input  logic                  r0_req_valid,
    output logic                  r0_req_ready,
    input  logic [31:0]           r0_req_addr,
    output logic                  r0_resp_valid,
    input  logic                  r0_resp_ready,
    output logic [31:0]           r0_resp_data,
    output logic                  r0_resp_err,

    input  logic                  r1_req_valid,
    output logic                  r1_req_ready,
    input  logic [31:0]           r1_req_addr,
    output logic                  r1_resp_valid,
    input  logic                  r1_resp_ready,
    output logic [31:0]           r1_resp_data,
    output logic                  r1_resp_err,

    output logic                  rom_me,
    output logic                  rom_oe,
    output logic [DEPTH_LOG2-1:0] rom_address,
    input  logic [31:0]           rom_q
);

    // state   | meaning
    // IDLE    | arbitrate between requesters, accept at most one request
    // ISSUE   | rom_me high with the latched word index on rom_address
    // CAPTURE | rom_oe high, rom_q registered into the response word
    // RESP    | response held for the latched requester until resp_ready

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        CAPTURE = 2'd2,
        RESP    = 2'd3
    } state_t;

    // 33-bit window bounds so BASE_ADDR + size cannot wrap past 2^32
    localparam logic [32:0] BASE_EXT  = {1'b0, BASE_ADDR};
    localparam logic [32:0] LIMIT_EXT = BASE_EXT + (33'd4 << DEPTH_LOG2);

    state_t                state_q, state_d;
    logic                  rr_q, rr_d;
    logic                  id_q, id_d;
    logic                  err_q, err_d;
    logic [31:0]           data_q, data_d;
    logic [DEPTH_LOG2-1:0] addr_q, addr_d;

    logic                  gnt_valid;
    logic                  gnt_id;
    logic [31:0]           sel_addr;
    logic [31:0]           offset;
    logic [DEPTH_LOG2-1:0] sel_idx;
    logic                  sel_err;
    logic                  sel_resp_ready;
    logic                  unused_offset;

    always_comb begin
        gnt_valid = 1'b0;
        gnt_id    = 1'b0;
        if (state_q == IDLE && !reset) begin
            if (r0_req_valid && r1_req_valid) begin
                gnt_valid = 1'b1;
                gnt_id    = rr_q;
            end else if (r0_req_valid) begin
                gnt_valid = 1'b1;
                gnt_id    = 1'b0;
            end else if (r1_req_valid) begin
                gnt_valid = 1'b1;
                gnt_id    = 1'b1;
            end
        end
    end

    assign sel_addr      = gnt_id ? r1_req_addr : r0_req_addr;
    assign offset        = sel_addr - BASE_ADDR;
    assign sel_idx       = offset[DEPTH_LOG2+1:2];
    assign unused_offset = ^{offset[31:DEPTH_LOG2+2], offset[1:0]};

    assign sel_err = (sel_addr[1:0] != 2'b00)
                   || ({1'b0, sel_addr} < BASE_EXT)
                   || ({1'b0, sel_addr} >= LIMIT_EXT);

    assign sel_resp_ready = id_q ? r1_resp_ready : r0_resp_ready;

    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        id_d    = id_q;
        err_d   = err_q;
        data_d  = data_q;
        addr_d  = addr_q;
        case (state_q)
            IDLE: begin
                if (gnt_valid) begin
                    id_d  = gnt_id;
                    err_d = sel_err;
                    rr_d  = ~gnt_id;
                    if (sel_err) begin
                        // error transactions skip the ROM and leave rom_address untouched
                        data_d  = 32'h0;
                        state_d = RESP;
                    end else begin
                        addr_d  = sel_idx;
                        state_d = ISSUE;
                    end
                end
            end
            ISSUE: begin
                state_d = CAPTURE;
            end
            CAPTURE: begin
                data_d  = rom_q;
                state_d = RESP;
            end
            RESP: begin
                if (sel_resp_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            rr_q    <= 1'b0;
            id_q    <= 1'b0;
            err_q   <= 1'b0;
            data_q  <= 32'h0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            id_q    <= id_d;
            err_q   <= err_d;
            data_q  <= data_d;
            addr_q  <= addr_d;
        end
    end

    assign r0_req_ready  = gnt_valid && !gnt_id;
    assign r1_req_ready  = gnt_valid && gnt_id;

    assign r0_resp_valid = (state_q == RESP) && !id_q;
    assign r1_resp_valid = (state_q == RESP) && id_q;
    assign r0_resp_data  = r0_resp_valid ? data_q : 32'h0;
    assign r1_resp_data  = r1_resp_valid ? data_q : 32'h0;
    assign r0_resp_err   = r0_resp_valid && err_q;
    assign r1_resp_err   = r1_resp_valid && err_q;

    assign rom_me        = (state_q == ISSUE);
    assign rom_oe        = (state_q == CAPTURE);
    assign rom_address   = addr_q;

endmodule
